bitstream_count: RTL and testbench

BITSTREAM_COUNT -- requirements
Module: bitstream_count

---
 rtl/bitstream_count.sv | 99 +++++++++
 tb/tb_bitstream_count.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bitstream_count.sv
// Multi-cycle popcount of a BITSTREAM-bit frame, CHUNK bits per cycle, with valid/ready on both sides.
// Optional macro BSC_BIPOLAR_EN turns the result into the signed value 2*count - BITSTREAM.
module bitstream_count #(
  parameter int BITSTREAM = 64,
  parameter int CHUNK     = 8,   // BITSTREAM must be a multiple of CHUNK
  localparam int N  = BITSTREAM / CHUNK,
  localparam int CW = $clog2(BITSTREAM + 1),
`ifdef BSC_BIPOLAR_EN
  localparam int OW = CW + 1
`else
  localparam int OW = CW
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t               state, next;
  logic [BITSTREAM-1:0] shreg;
  logic [CW-1:0]        acc;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        chunk_pc;
  logic [CW-1:0]        sum;
  logic [OW-1:0]        res;
  logic                 last;
  logic                 accept;
  logic                 fire;

  always_comb begin
    chunk_pc = '0;
    for (int i = 0; i < CHUNK; i++)
      chunk_pc = chunk_pc + CW'(shreg[i]);
  end

  // acc never exceeds BITSTREAM, so CW bits cannot overflow
  assign sum    = acc + chunk_pc;
  assign last   = (idx == IW'(N - 1));
  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

`ifdef BSC_BIPOLAR_EN
  // 2*count - BITSTREAM in two's complement; wraparound of the unsigned subtract gives the sign
  assign res = {sum, 1'b0} - OW'(BITSTREAM);
`else
  assign res = sum;
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = COUNT;
      COUNT:   if (last)   next = DONE;
      DONE:    if (fire)   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      acc       <= '0;
      idx       <= '0;
      shreg     <= '0;
    end else begin
      state     <= next;
      // registered so ready stays low through reset and rises on the first edge after it
      in_ready  <= (next == IDLE);
      out_valid <= (next == DONE);
      case (state)
        IDLE: if (accept) begin
          shreg <= in_bits;
          acc   <= '0;
          idx   <= '0;
        end
        COUNT: begin
          shreg <= shreg >> CHUNK;
          acc   <= sum;
          idx   <= idx + IW'(1);
          if (last) out_count <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_count.sv
// Table-driven scoreboard bench for bitstream_count at default parameters.
module tb_bitstream_count;

  localparam int BITSTREAM = 64;
  localparam int N         = 8;
  localparam int CW        = 7;
`ifdef BSC_BIPOLAR_EN
  localparam int OW = CW + 1;
`else
  localparam int OW = CW;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [BITSTREAM-1:0] in_bits;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_count;

  bitstream_count #(.BITSTREAM(BITSTREAM), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bits;
    int          cnt;    // expected number of ones
    int          hold;   // cycles of out_ready low in DONE
    bit          busy;   // keep in_valid high with changing bits during COUNT
  } vec_t;

  vec_t          vecs[10];
  logic [OW-1:0] sb[$];
  int            ncomp = 0;
  int            nfail = 0;

  function automatic logic [OW-1:0] conv(int c);
`ifdef BSC_BIPOLAR_EN
    return OW'(2 * c - BITSTREAM);
`else
    return OW'(c);
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(logic [63:0] bits, int cnt, int hold, bit busy);
    int w;
    int lat;
    logic [OW-1:0] e;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_frame", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_bits  = bits;
    sb.push_back(conv(cnt));
    @(negedge clk);
    if (!busy) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("ready_low_in_count", 64'(in_ready), 64'd0);
      if (busy) in_bits = {$urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(N));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("count", 64'(out_count), 64'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_count", 64'(out_count), 64'(e));
      chk("hold_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{64'h0000_0000_0000_0000,  0, 0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 1'b0};
    vecs[2] = '{64'h0000_0000_FFFF_FFFF, 32, 0, 1'b0};
    vecs[3] = '{64'h8000_0000_7FFF_FFFF, 32, 0, 1'b0};
    vecs[4] = '{64'hC000_0000_3FFF_FFFF, 32, 0, 1'b0};
    vecs[5] = '{64'hE000_0000_1FFF_FFFF, 32, 1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0001,  2, 5, 1'b0};
    vecs[7] = '{64'h0123_4567_89AB_CDEF, 32, 2, 1'b1};
    vecs[8] = '{64'hF0F0_0000_0000_00FF, 16, 0, 1'b0};
    vecs[9] = '{64'h0000_0000_0000_0001,  1, 0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bits = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].bits, vecs[i].cnt, vecs[i].hold, vecs[i].busy);

    for (int i = 0; i < 4; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      run_frame(r, $countones(r), i, 1'b0);
    end

    // Reset mid-COUNT: everything clears at once and the frame is dropped.
    in_valid = 1'b1;
    in_bits  = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_result_after_abort", 64'(seen), 64'd0);
    run_frame(64'h0000_0000_0000_000F, 4, 0, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
